btn_debounce_pulse: RTL and testbench

Conditions a raw board push-button into clean control strobes for the 4-bit up-counter stage. The block synchronises the button, debounces it with a stability-count FSM and emits a one-cycle press strobe. That strobe is the counter's increment enable. Optional auto-repeat re-issues the strobe while the button is held.

---
 rtl/btn_debounce_pulse_if.sv | 26 ++
 rtl/btn_debounce_pulse.sv | 139 +++++++++++++
 tb/tb_btn_debounce_pulse.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_pulse_if.sv
// Signal bundle between a raw push-button source and the debounce/strobe block.
// The master side drives the raw button; the slave side (the debouncer) returns
// the conditioned level, the press/repeat and release strobes, and a busy flag.
interface btn_debounce_pulse_if;
    logic btn_in;     // raw asynchronous button, 1 = pressed
    logic btn_level;  // debounced button level
    logic btn_pulse;  // one-cycle strobe on accepted press and each auto-repeat
    logic rel_pulse;  // one-cycle strobe on accepted release
    logic busy;       // a level change is currently being qualified

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_pulse,
        input  rel_pulse,
        input  busy
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_pulse,
        output rel_pulse,
        output busy
    );
endinterface

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner feeding the increment enable of the 4-bit counter.
// The raw button passes through a two-flop synchroniser, a stability-count FSM
// accepts a level change only after DB_CYCLES identical samples, and the FSM
// emits one-cycle press/release strobes. With REPEAT_DLY > 0 the press strobe
// is re-issued after REPEAT_DLY held cycles and then every REPEAT_PER cycles.
module btn_debounce_pulse #(
    parameter int DB_CYCLES  = 4,
    parameter int REPEAT_DLY = 0,
    parameter int REPEAT_PER = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    btn_debounce_pulse_if.slave  bus
);

    localparam int SW = $clog2(DB_CYCLES) + 1;
    localparam int HW = $clog2(REPEAT_DLY + 1) + 1;

    localparam logic [SW-1:0] STAB_ONE    = SW'(1);
    localparam logic [SW-1:0] STAB_LAST   = SW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DLY - 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DLY - REPEAT_PER);
    localparam bit            REPEAT_EN   = (REPEAT_DLY > 0);

    // Reject parameter values the counters and compare points cannot represent.
    if (DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_bad_db_cycles
        $error("btn_debounce_pulse: DB_CYCLES must be in 2..65535");
    end
    if (REPEAT_DLY < 0) begin : g_bad_repeat_dly
        $error("btn_debounce_pulse: REPEAT_DLY must be >= 0");
    end
    if (REPEAT_DLY > 0 && (REPEAT_PER < 2 || REPEAT_PER > REPEAT_DLY)) begin : g_bad_repeat_per
        $error("btn_debounce_pulse: REPEAT_PER must be in 2..REPEAT_DLY");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic            sync_p0;
    logic            sync_p1;
    state_t          state;
    logic [SW-1:0]   stab_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            level_q;
    logic            pulse_q;
    logic            rel_q;

    // Two-flop synchroniser: sync_p1 is the only button sample the FSM ever sees.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= bus.btn_in;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce FSM with stability counter, hold/repeat counter and registered strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            stab_cnt <= '0;
            hold_cnt <= '0;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            // Strobes are single-cycle: cleared unless re-armed below.
            pulse_q <= 1'b0;
            rel_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_p1) begin
                        state    <= PRESS_WAIT;
                        stab_cnt <= STAB_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_p1) begin
                        // Bounce: drop the partial count, level never changed.
                        state    <= IDLE;
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state    <= PRESSED;
                        stab_cnt <= '0;
                        hold_cnt <= '0;
                        level_q  <= 1'b1;
                        pulse_q  <= 1'b1;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!sync_p1) begin
                        // hold_cnt is kept so a release bounce does not restart repeat timing.
                        state    <= RELEASE_WAIT;
                        stab_cnt <= STAB_ONE;
                    end else if (REPEAT_EN) begin
                        if (hold_cnt == HOLD_LAST) begin
                            // Reload so the next hit lands REPEAT_PER cycles later.
                            pulse_q  <= 1'b1;
                            hold_cnt <= HOLD_RELOAD;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_p1) begin
                        state    <= PRESSED;
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state    <= IDLE;
                        stab_cnt <= '0;
                        level_q  <= 1'b0;
                        rel_q    <= 1'b1;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    stab_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.btn_level = level_q;
    assign bus.btn_pulse = pulse_q;
    assign bus.rel_pulse = rel_q;
    assign bus.busy      = (state == PRESS_WAIT) || (state == RELEASE_WAIT);

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: three instances with different parameter sets
// share one button/reset stimulus and are compared every cycle against a
// run-length reference model, plus directed checks on the key scenarios.
module tb_btn_debounce_pulse;

    localparam int N = 3;
    localparam int DB0 = 4, DLY0 = 0,  PER0 = 4;
    localparam int DB1 = 4, DLY1 = 10, PER1 = 4;
    localparam int DB2 = 3, DLY2 = 5,  PER2 = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_in;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    btn_debounce_pulse_if bus0 ();
    btn_debounce_pulse_if bus1 ();
    btn_debounce_pulse_if bus2 ();

    assign bus0.btn_in = btn_in;
    assign bus1.btn_in = btn_in;
    assign bus2.btn_in = btn_in;

    btn_debounce_pulse #(.DB_CYCLES(DB0), .REPEAT_DLY(DLY0), .REPEAT_PER(PER0))
        dut0 (.clk(clk), .rst(rst_n), .bus(bus0));
    btn_debounce_pulse #(.DB_CYCLES(DB1), .REPEAT_DLY(DLY1), .REPEAT_PER(PER1))
        dut1 (.clk(clk), .rst(rst_n), .bus(bus1));
    btn_debounce_pulse #(.DB_CYCLES(DB2), .REPEAT_DLY(DLY2), .REPEAT_PER(PER2))
        dut2 (.clk(clk), .rst(rst_n), .bus(bus2));

    logic [N-1:0] o_level, o_pulse, o_rel, o_busy;
    assign o_level = {bus2.btn_level, bus1.btn_level, bus0.btn_level};
    assign o_pulse = {bus2.btn_pulse, bus1.btn_pulse, bus0.btn_pulse};
    assign o_rel   = {bus2.rel_pulse, bus1.rel_pulse, bus0.rel_pulse};
    assign o_busy  = {bus2.busy,      bus1.busy,      bus0.busy};

    function automatic int db_of(input int k);
        case (k)
            0:       return DB0;
            1:       return DB1;
            default: return DB2;
        endcase
    endfunction

    function automatic int dly_of(input int k);
        case (k)
            0:       return DLY0;
            1:       return DLY1;
            default: return DLY2;
        endcase
    endfunction

    function automatic int per_of(input int k);
        case (k)
            0:       return PER0;
            1:       return PER1;
            default: return PER2;
        endcase
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: a level flips once DB consecutive synchronised samples
    // disagree with it; repeats fire at held-cycle counts DLY, DLY+PER, ...
    logic         m_s1, m_s2;
    logic [N-1:0] m_level, m_pulse, m_rel;
    int           m_run [N];
    int           m_h   [N];

    // Model update on every clock edge, asynchronously cleared like the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1    <= 1'b0;
            m_s2    <= 1'b0;
            m_level <= '0;
            m_pulse <= '0;
            m_rel   <= '0;
            for (int k = 0; k < N; k++) begin
                m_run[k] <= 0;
                m_h[k]   <= 0;
            end
        end else begin
            m_s1 <= btn_in;
            m_s2 <= m_s1;
            for (int k = 0; k < N; k++) begin
                int   run;
                int   h;
                logic lvl;
                logic p;
                logic r;
                run = m_run[k];
                h   = m_h[k];
                lvl = m_level[k];
                p   = 1'b0;
                r   = 1'b0;
                if (m_s2 != lvl) begin
                    run = run + 1;
                    if (run == db_of(k)) begin
                        lvl = ~lvl;
                        run = 0;
                        if (lvl) begin
                            p = 1'b1;
                            h = 0;
                        end else begin
                            r = 1'b1;
                        end
                    end
                end else begin
                    // Held cycles only count while settled in the pressed level.
                    if (lvl && run == 0 && dly_of(k) > 0) begin
                        h = h + 1;
                        if (h >= dly_of(k) && ((h - dly_of(k)) % per_of(k)) == 0)
                            p = 1'b1;
                    end
                    run = 0;
                end
                m_run[k]   <= run;
                m_h[k]     <= h;
                m_level[k] <= lvl;
                m_pulse[k] <= p;
                m_rel[k]   <= r;
            end
        end
    end

    int pulse_cnt [N];
    int rel_cnt   [N];
    int busy_cnt  [N];

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            check($sformatf("level[%0d]", k), o_level[k], m_level[k]);
            check($sformatf("pulse[%0d]", k), o_pulse[k], m_pulse[k]);
            check($sformatf("rel[%0d]", k),   o_rel[k],   m_rel[k]);
            check($sformatf("busy[%0d]", k),  o_busy[k],  (m_run[k] > 0));
        end
    end

    // Strobe and busy tallies used by the directed scenario checks.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (o_pulse[k]) pulse_cnt[k] <= pulse_cnt[k] + 1;
            if (o_rel[k])   rel_cnt[k]   <= rel_cnt[k] + 1;
            if (o_busy[k])  busy_cnt[k]  <= busy_cnt[k] + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int  p0, r0, b0, p1;
        bit  found;

        for (int k = 0; k < N; k++) begin
            pulse_cnt[k] = 0;
            rel_cnt[k]   = 0;
            busy_cnt[k]  = 0;
        end
        rst_n  = 1'b0;
        btn_in = 1'b0;

        // Reset held while the button chatters: everything stays cleared.
        for (int i = 0; i < 6; i++) begin
            btn_in = 1'($urandom_range(0, 1));
            tick(1);
        end
        check("rst_level", o_level[0], 1'b0);
        check("rst_pulse", o_pulse[0], 1'b0);
        check("rst_rel",   o_rel[0],   1'b0);
        check("rst_busy",  o_busy[0],  1'b0);
        btn_in = 1'b0;
        rst_n  = 1'b1;
        tick(20);
        check("idle_level", o_level[0], 1'b0);
        check_int("idle_pulses", pulse_cnt[0], 0);

        // Clean press: level and strobe appear after edge DB+2, strobe lasts one cycle.
        btn_in = 1'b1;
        tick(6);
        check("press_level", o_level[0], 1'b1);
        check("press_pulse", o_pulse[0], 1'b1);
        tick(1);
        check("press_pulse_end", o_pulse[0], 1'b0);
        check("press_level_hold", o_level[0], 1'b1);
        tick(4);
        btn_in = 1'b0;
        tick(6);
        check("release_rel",   o_rel[0],   1'b1);
        check("release_level", o_level[0], 1'b0);
        tick(1);
        check("release_rel_end", o_rel[0], 1'b0);
        tick(5);

        // Bounce shorter than DB_CYCLES: no strobe, level stays low, busy toggles.
        p0 = pulse_cnt[0];
        b0 = busy_cnt[0];
        btn_in = 1'b1; tick(3);
        btn_in = 1'b0; tick(1);
        btn_in = 1'b1; tick(2);
        btn_in = 1'b0; tick(8);
        check_int("bounce_pulses", pulse_cnt[0] - p0, 0);
        check("bounce_level", o_level[0], 1'b0);
        check("bounce_busy_seen", (busy_cnt[0] - b0) > 0, 1'b1);
        p0 = pulse_cnt[0];
        btn_in = 1'b1; tick(8);
        check_int("press_after_bounce", pulse_cnt[0] - p0, 1);
        check("press_after_bounce_level", o_level[0], 1'b1);

        // Release bounce while pressed: no release strobe and no extra press strobe.
        p0 = pulse_cnt[0];
        r0 = rel_cnt[0];
        btn_in = 1'b0; tick(2);
        btn_in = 1'b1; tick(8);
        check_int("relbounce_rel",   rel_cnt[0] - r0,   0);
        check_int("relbounce_pulse", pulse_cnt[0] - p0, 0);
        check("relbounce_level", o_level[0], 1'b1);
        btn_in = 1'b0; tick(10);
        check("relbounce_final_level", o_level[0], 1'b0);

        // Auto-repeat on dut1: strobes at P, P+10, P+14, P+18, P+22, P+26.
        tick(5);
        p1 = pulse_cnt[1];
        btn_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (o_pulse[1]) found = 1'b1;
        end
        check("repeat_first_strobe_seen", found, 1'b1);
        tick(27);
        btn_in = 1'b0;
        tick(10);
        check_int("repeat_strobe_count", pulse_cnt[1] - p1, 6);
        check("repeat_level_after", o_level[1], 1'b0);

        // Reset in the middle of qualification, button held through release.
        tick(5);
        btn_in = 1'b1;
        tick(4);
        check("midrst_busy_before", o_busy[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",  o_busy[0],  1'b0);
        check("midrst_level", o_level[0], 1'b0);
        check("midrst_pulse", o_pulse[0], 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("midrst_no_early_pulse", o_pulse[0], 1'b0);
        tick(1);
        check("midrst_pulse_after", o_pulse[0], 1'b1);
        check("midrst_level_after", o_level[0], 1'b1);
        tick(5);
        btn_in = 1'b0;
        tick(10);

        // Random run lengths around the debounce threshold.
        for (int i = 0; i < 60; i++) begin
            btn_in = 1'($urandom_range(0, 1));
            tick(int'($urandom_range(1, 14)));
        end
        btn_in = 1'b0;
        tick(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
